// File: rtl/sumador_secuencial.sv
// Multi-cycle WORDS*BITS-bit adder/subtractor: one BITS-wide chunk per clock,
// least-significant chunk first, carry held in a register between chunks.
module sumador_secuencial #(
    parameter int BITS  = 4,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [BITS*WORDS-1:0] num1,
    input  logic [BITS*WORDS-1:0] num2,
    output logic                  busy,
    output logic                  done,
    output logic [BITS*WORDS-1:0] result,
    output logic                  Cout,
    output logic                  overflow
);
    localparam int W  = BITS * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, next_state;
    logic [W-1:0]    a, b;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [BITS-1:0] a_ch, b_ch;
    logic [BITS:0]   csum;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (idx == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Shared chunk adder; the operand chunk is picked by idx.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (idx == IW'(k)) begin
                a_ch = a[k*BITS +: BITS];
                b_ch = b[k*BITS +: BITS];
            end
        end
        csum = {1'b0, a_ch} + {1'b0, b_ch} + {{BITS{1'b0}}, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= num1;
                        b     <= sub ? ~num2 : num2;
                        carry <= sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        if (idx == IW'(k)) result[k*BITS +: BITS] <= csum[BITS-1:0];
                    end
                    carry <= csum[BITS];
                    if (idx == LAST) begin
                        Cout     <= csum[BITS];
                        overflow <= (a[W-1] == b[W-1]) && (csum[BITS-1] != a[W-1]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sumador_secuencial.sv
// Directed bench for sumador_secuencial (16-bit and 8-bit single-chunk builds)
// with a scoreboard queue of full-width reference results.
module tb_sumador_secuencial;
    logic        clk = 1'b0;
    logic        rst;
    logic        start16, sub16, busy16, done16, cout16, ov16;
    logic [15:0] n1_16, n2_16, res16;
    logic        start8, sub8, busy8, done8, cout8, ov8;
    logic [7:0]  n1_8, n2_8, res8;

    int ncmp  = 0;
    int nfail = 0;
    logic [17:0] q16[$];
    logic [9:0]  q8[$];

    always #5 clk = ~clk;

    sumador_secuencial #(.BITS(4), .WORDS(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .num1(n1_16), .num2(n2_16),
        .busy(busy16), .done(done16), .result(res16), .Cout(cout16), .overflow(ov16)
    );

    sumador_secuencial #(.BITS(8), .WORDS(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .num1(n1_8), .num2(n2_8),
        .busy(busy8), .done(done8), .result(res8), .Cout(cout8), .overflow(ov8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carry, result} from a full-width add.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yy;
        logic [16:0] t;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {16'd0, s};
        return {(x[15] == yy[15]) && (t[15] != x[15]), t};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [7:0] yy;
        logic [8:0] t;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {8'd0, s};
        return {(x[7] == yy[7]) && (t[7] != x[7]), t};
    endfunction

    // Called at a negedge; returns at the negedge of RUN cycle 1.
    task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic s, input bit push);
        start16 = 1'b1; n1_16 = x; n2_16 = y; sub16 = s;
        if (push) q16.push_back(model16(x, y, s));
        @(negedge clk);
        start16 = 1'b0;
        chk("busy16_run", busy16, 1);
    endtask

    task automatic finish16(input int cnt0, input string tag);
        int cnt;
        logic [17:0] e;
        cnt = cnt0;
        while (!done16 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 5);
        chk({tag, "_done"}, done16, 1);
        chk({tag, "_busy_at_done"}, busy16, 1);
        chk({tag, "_queue"}, q16.size() != 0, 1);
        if (q16.size() != 0) begin
            e = q16.pop_front();
            chk({tag, "_result"}, res16, e[15:0]);
            chk({tag, "_cout"}, cout16, e[16]);
            chk({tag, "_overflow"}, ov16, e[17]);
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, done16, 0);
        chk({tag, "_busy_after"}, busy16, 0);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
        int cnt;
        logic [9:0] e;
        start8 = 1'b1; n1_8 = x; n2_8 = y; sub8 = s;
        q8.push_back(model8(x, y, s));
        @(negedge clk);
        start8 = 1'b0;
        cnt = 1;
        while (!done8 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 2);
        e = q8.pop_front();
        chk({tag, "_result"}, res8, e[7:0]);
        chk({tag, "_cout"}, cout8, e[8]);
        chk({tag, "_overflow"}, ov8, e[9]);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done8, 0);
    endtask

    initial begin
        int ndone;
        logic [9:0] e8;
        rst = 1'b1;
        start16 = 1'b0; sub16 = 1'b0; n1_16 = '0; n2_16 = '0;
        start8  = 1'b0; sub8  = 1'b0; n1_8  = '0; n2_8  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy16", busy16, 0);
        chk("rst_done16", done16, 0);
        chk("rst_result16", res16, 0);
        chk("rst_cout16", cout16, 0);
        chk("rst_ov16", ov16, 0);
        chk("rst_busy8", busy8, 0);
        rst = 1'b0;
        @(negedge clk);

        issue16(16'h1234, 16'h0FFF, 1'b0, 1'b1); finish16(1, "add_1234");
        chk("add_1234_literal", res16, 16'h2233);
        issue16(16'hFFFF, 16'h0001, 1'b0, 1'b1); finish16(1, "add_ffff");
        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b1); finish16(1, "add_7fff");
        issue16(16'h8000, 16'h0001, 1'b1, 1'b1); finish16(1, "sub_8000");
        issue16(16'h0005, 16'h0007, 1'b1, 1'b1); finish16(1, "sub_0005");

        // Start pulse and operand changes during RUN must be ignored.
        issue16(16'h1111, 16'h2222, 1'b0, 1'b1);
        @(negedge clk);
        start16 = 1'b1; n1_16 = 16'hFFFF; n2_16 = 16'h5A5A; sub16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        finish16(3, "ignore");
        chk("ignore_literal", res16, 16'h3333);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done16) ndone++;
        end
        chk("ignore_no_extra_done", ndone, 0);

        // Reset during RUN cycle 2 aborts the operation.
        issue16(16'h0001, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy16, 0);
        chk("abort_done", done16, 0);
        chk("abort_result", res16, 0);
        chk("abort_cout", cout16, 0);
        chk("abort_ov", ov16, 0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done16) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        issue16(16'hABCD, 16'h1357, 1'b1, 1'b1); finish16(1, "after_rst");

        op8(8'hC8, 8'h64, 1'b0, "w1_add");
        chk("w1_add_literal", res8, 8'h2C);

        // start held high: accepts every 3rd cycle with changing operands.
        for (int n = 0; n < 10; n++) begin
            if (n > 0) begin
                chk("b2b_done", done8, (n % 3 == 2));
                if (done8 && q8.size() != 0) begin
                    e8 = q8.pop_front();
                    chk("b2b_result", res8, e8[7:0]);
                    chk("b2b_cout", cout8, e8[8]);
                    chk("b2b_overflow", ov8, e8[9]);
                end
            end
            if (n < 9) begin
                start8 = 1'b1;
                n1_8 = 8'(n * 37 + 5);
                n2_8 = 8'(n * 91 + 200);
                sub8 = n[0];
                if (n % 3 == 0) q8.push_back(model8(n1_8, n2_8, sub8));
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_queue_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/sumador_secuencial.md
Name: sumador_secuencial

Overview:
- Multi-cycle wide adder/subtractor controller.
- Adds or subtracts two WORDS*BITS-bit operands using one BITS-wide ripple-carry chunk per clock, least-significant chunk first.
- Holds the inter-chunk carry in a register and sequences the chunks with a start/busy/done handshake.
- Sits between the control FSM of the lab datapath and the result register file. Wide arithmetic costs one BITS-wide adder instead of a full WORDS*BITS ripple chain.

Parameters:
BITS, 4, width of one chunk adder (>=1)
WORDS, 4, number of chunks per operand (>=1); total width W = BITS*WORDS

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request an operation; sampled only in IDLE
sub  input  1  0 = num1+num2, 1 = num1-num2; latched with operands on accepted start
num1  input  W  operand A; latched on accepted start
num2  input  W  operand B; latched on accepted start
busy  output  1  high while in RUN or DONE
done  output  1  one-cycle pulse, result/Cout/overflow valid
result  output  W  sum/difference register
Cout  output  1  final carry out (for sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow of the W-bit operation

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset, any state: next edge forces IDLE with idx=0, carry=0, busy=0, done=0, result=0, Cout=0, overflow=0. Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1 (accepted):
  - Latch a=num1, b=(sub ? ~num2 : num2), carry=sub, idx=0; go RUN.
  - result is not cleared; it keeps its previous value until chunks are overwritten.
- IDLE, start=0: stay; outputs hold their last values, except done=0.
- RUN, each cycle, using chunk k=idx:
  - {c,s} = a[k] + b[k] + carry, computed at BITS+1 bits.
  - result chunk k <= s; carry <= c.
  - If idx==WORDS-1:
    - Cout <= c.
    - overflow <= (a_msb == b_msb) && (s_msb != a_msb), where a_msb/b_msb are the MSBs of latched a/b (b already inverted for sub) and s_msb is the MSB of s.
    - Go DONE.
  - Else idx <= idx+1.
- DONE: done=1 for exactly this cycle; busy=1; next state IDLE unconditionally.
- Latency: start accepted at edge t; done high during the cycle after edge t+WORDS (WORDS RUN cycles, then 1 DONE cycle). Next start can be accepted in the cycle after DONE.
- start while busy (RUN or DONE) is ignored, not queued.
- Changes on num1/num2/sub after acceptance have no effect.
- result, Cout and overflow hold after DONE until the next accepted start begins overwriting them.
- Intermediate result chunks are visible during RUN. Consumers must qualify with done.
- Arithmetic is modulo 2^W; no saturation.
- idx is ceil(log2(WORDS)) bits, minimum 1 bit. WORDS=1 gives 1 RUN cycle.
- Pure chunk add requires no multiplication; a shared chunk adder with carry-in is built inside this block.

Test Plan:
- BITS=4, WORDS=4: start with num1=16'h1234, num2=16'h0FFF, sub=0 -> busy for 5 cycles; done one cycle, 5 cycles after accept edge; result=16'h2233, Cout=0, overflow=0.
- 16'hFFFF + 16'h0001, sub=0 -> result=16'h0000, Cout=1, overflow=0. Carry must ripple through all 4 chunk cycles.
- 16'h7FFF + 16'h0001, sub=0 -> result=16'h8000, Cout=0, overflow=1. Then 16'h8000 - 16'h0001, sub=1 -> result=16'h7FFF, Cout=1, overflow=1.
- 16'h0005 - 16'h0007, sub=1 -> result=16'hFFFE, Cout=0 (borrow), overflow=0.
- Accept 16'h1111+16'h2222; during RUN, pulse start with num1=16'hFFFF and change num2 -> ignored, result=16'h3333, single done. Then new op 16'h0001+16'h0001 with rst asserted at RUN cycle 2 -> next cycle IDLE, all outputs 0, no done. A start after reset completes normally.
- BITS=8, WORDS=1: 8'hC8 + 8'h64 -> done 1 cycle after the RUN cycle; result=8'h2C, Cout=1, overflow=0. Back-to-back starts are accepted every 3rd cycle.
